counter_arbiter: RTL and testbench

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arbiter.sv | 90 +++++++++
 tb/tb_counter_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - two-requester arbiter sharing one 4-bit down-counter
// Moore FSM IDLE -> LOAD -> RUN -> DONE; grant and latched length are held for the whole interval.
module counter_arbiter #(
  parameter int RR_MODE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [3:0] len0,
  input  logic [3:0] len1,
  output logic [1:0] grant,
  output logic [3:0] count,
  output logic       busy,
  output logic [1:0] done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       last;
  logic       win;
  logic [3:0] len_q;

  // win is the index of the requester that would be granted this cycle
  always_comb begin
    win = 1'b0;
    if (RR_MODE != 0) begin
      win = (req == 2'b11) ? ~last : req[1];
    end else begin
      win = ~req[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (count == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // last starts at 1 so requester 0 wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant <= 2'b00;
      count <= 4'd0;
      len_q <= 4'd0;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= win ? 2'b10 : 2'b01;
            len_q <= win ? len1 : len0;
          end
        end
        LOAD: count <= len_q;
        RUN: begin
          if (count != 4'd0) count <= count - 4'd1;
        end
        DONE: begin
          last  <= grant[1];
          grant <= 2'b00;
        end
        default: grant <= 2'b00;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE) ? grant : 2'b00;

endmodule

// File: tb/tb_counter_arbiter.sv
// tb/tb_counter_arbiter.sv - scoreboard bench for counter_arbiter
// Stimulus pushes expected done pulses (value, cycle); a negedge monitor pops and compares.
module tb_counter_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [3:0] len0, len1;
  logic [1:0] grant, done;
  logic [3:0] count;
  logic       busy;

  logic [1:0] grant_fp, done_fp;
  logic [3:0] count_fp;
  logic       busy_fp;

  typedef struct {
    logic [1:0] val;
    int         cyc;
  } entry_t;

  entry_t sb[$];
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  int     fp_done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  counter_arbiter #(.RR_MODE(1)) dut (
    .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1),
    .grant(grant), .count(count), .busy(busy), .done(done)
  );

  counter_arbiter #(.RR_MODE(0)) dut_fp (
    .clk(clk), .reset(reset), .req(2'b11), .len0(4'd1), .len1(4'd5),
    .grant(grant_fp), .count(count_fp), .busy(busy_fp), .done(done_fp)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [1:0] v, input int c);
    entry_t e;
    e.val = v;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_grant"}, int'(grant), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_busy"},  int'(busy),  0);
    chk({tag, "_done"},  int'(done),  0);
  endtask

  // drives one request right after an edge and follows grant/count until DONE
  task automatic run_one(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1,
                         input logic [1:0] exp, input int len);
    int k;
    int ec;
    @(posedge clk); #1;
    req = r; len0 = l0; len1 = l1;
    k = cyc;
    push(exp, k + len + 3);
    for (int i = 1; i <= len + 3; i++) begin
      @(posedge clk); #1;
      chk("run_grant", int'(grant), int'(exp));
      if (i >= 2) begin
        ec = (i - 2 >= len) ? 0 : len - (i - 2);
        chk("run_count", int'(count), ec);
      end
    end
    req = 2'b00;
    @(posedge clk); #1;
    chk("after_busy",  int'(busy),  0);
    chk("after_grant", int'(grant), 0);
  endtask

  always @(negedge clk) begin
    entry_t e;
    if (done !== 2'b00) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got %b at cycle %0d expected none", done, cyc);
      end else begin
        e = sb.pop_front();
        if (done !== e.val || cyc != e.cyc) begin
          errors++;
          $display("FAIL done: got %b at cycle %0d expected %b at cycle %0d", done, cyc, e.val, e.cyc);
        end
      end
      checks++;
      if (done !== grant) begin
        errors++;
        $display("FAIL done_vs_grant: got done %b grant %b expected equal", done, grant);
      end
    end
    if (grant_fp !== 2'b00) begin
      checks++;
      if (grant_fp !== 2'b01) begin
        errors++;
        $display("FAIL fp_grant: got %b expected 01", grant_fp);
      end
    end
    if (done_fp === 2'b01) fp_done_cnt++;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int r;
    int wait_cnt;
    reset = 1'b1; req = 2'b00; len0 = 4'd0; len1 = 4'd0;
    repeat (3) @(posedge clk); #1;
    chk_idle_outputs("reset");
    reset = 1'b0;

    // single request, len 3: done at +6
    run_one(2'b01, 4'd3, 4'd7, 2'b01, 3);
    // zero length on requester 1: done at +3
    run_one(2'b10, 4'd9, 4'd0, 2'b10, 0);

    // fresh reset so requester 0 wins the first tie
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk_idle_outputs("async_reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // tie, round-robin alternation 01,10,01,10
    @(posedge clk); #1;
    req = 2'b11; len0 = 4'd2; len1 = 4'd1;
    k = cyc;
    push(2'b01, k + 5);
    push(2'b10, k + 10);
    push(2'b01, k + 16);
    push(2'b10, k + 21);
    repeat (21) @(posedge clk); #1;
    req = 2'b00;
    repeat (2) @(posedge clk); #1;
    chk("tie_end_busy", int'(busy), 0);

    // input churn during RUN
    @(posedge clk); #1;
    req = 2'b01; len0 = 4'd4;
    k = cyc;
    push(2'b01, k + 7);
    repeat (3) @(posedge clk); #1;
    chk("churn_count_a", int'(count), 3);
    len0 = 4'd9; req = 2'b00;
    repeat (2) @(posedge clk); #1;
    chk("churn_count_b", int'(count), 1);
    repeat (3) @(posedge clk); #1;
    chk("churn_end_busy", int'(busy), 0);

    // reset mid-RUN at count 9, then a fresh 15-count interval
    @(posedge clk); #1;
    req = 2'b01; len0 = 4'd15;
    repeat (8) @(posedge clk); #1;
    chk("pre_reset_count", int'(count), 9);
    #2;
    reset = 1'b1;
    #1;
    chk_idle_outputs("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    r = cyc;
    push(2'b01, r + 18);
    for (int i = 1; i <= 18; i++) begin
      @(posedge clk); #1;
      if (i == 2) chk("restart_count", int'(count), 15);
    end
    req = 2'b00;

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 100) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    chk("fp_served_req0", (fp_done_cnt >= 5) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
